// File: rtl/overlay_pkg.sv
// rtl/overlay_pkg.sv - shared widths, scheduler state type and char codes for the overlay
package overlay_pkg;

    localparam int OVL_AW = 11;
    localparam int OVL_DW = 8;
    localparam int OVL_LW = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } sched_state_t;

    // Character codes written by the overlay content generators
    localparam logic [7:0] CHR_GEAR = 8'h2A;
    localparam logic [7:0] CHR_BAR  = 8'h96;
    localparam logic [7:0] CHR_FILL = 8'h7F;
    localparam logic [7:0] CHR_TEXT = 8'hA6;

endpackage

// File: rtl/overlay_rr_arb.sv
// rtl/overlay_rr_arb.sv - combinational round-robin pick starting at rr_ptr
module overlay_rr_arb #(
    parameter int NREQ = 4,
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic            found,
    output logic [IW-1:0]   idx
);

    // First asserted request at or after rr_ptr, wrapping modulo NREQ
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[(int'(rr_ptr) + k) % NREQ]) begin
                found = 1'b1;
                idx   = IW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/overlay_wr_sched.sv
// rtl/overlay_wr_sched.sv - burst write scheduler sharing the char RAM write port
module overlay_wr_sched
    import overlay_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = OVL_AW,
    parameter int DW   = OVL_DW,
    parameter int LW   = OVL_LW,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               i_clk,
    input  logic               reset,
    input  logic               vblank,
    input  logic               vblank_only,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*LW-1:0] req_len,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    req_done,
    output logic               wr_ena,
    output logic [AW-1:0]      wr_addr,
    output logic [DW-1:0]      wr_data,
    output logic               busy,
    output logic [IW-1:0]      grant_idx
);

    sched_state_t  state;
    logic [AW-1:0] base;
    logic [LW-1:0] len;
    logic [LW-1:0] beat;
    logic [IW-1:0] rr_ptr;

    logic          gate_open;
    logic          arb_found;
    logic [IW-1:0] arb_idx;
    logic          beat_fire;
    logic [DW-1:0] cur_data;

    assign gate_open = ~vblank_only | vblank;
    assign beat_fire = (state == BURST) & gate_open & req_valid[grant_idx];
    assign cur_data  = req_data[int'(grant_idx)*DW +: DW];

    overlay_rr_arb #(
        .NREQ(NREQ)
    ) u_arb (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .found  (arb_found),
        .idx    (arb_idx)
    );

    // Only the grantee sees ready, and only while the gate is open
    always_comb begin
        req_ready = '0;
        if (state == BURST) begin
            req_ready[grant_idx] = gate_open;
        end
    end

    // Grant/burst FSM with registered write port and done pulses
    always_ff @(posedge i_clk) begin
        if (reset) begin
            state     <= IDLE;
            base      <= '0;
            len       <= '0;
            beat      <= '0;
            rr_ptr    <= '0;
            wr_ena    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            req_done  <= '0;
            busy      <= 1'b0;
            grant_idx <= '0;
        end else begin
            wr_ena   <= 1'b0;
            req_done <= '0;
            case (state)
                IDLE: begin
                    if (gate_open && arb_found) begin
                        grant_idx <= arb_idx;
                        base      <= req_addr[int'(arb_idx)*AW +: AW];
                        len       <= req_len[int'(arb_idx)*LW +: LW];
                        beat      <= '0;
                        busy      <= 1'b1;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (beat_fire) begin
                        wr_ena  <= 1'b1;
                        wr_addr <= base + AW'(beat);
                        wr_data <= cur_data;
                        beat    <= beat + 1'b1;
                        if (beat == len) begin
                            req_done[grant_idx] <= 1'b1;
                            busy                <= 1'b0;
                            rr_ptr              <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
                            state               <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_overlay_wr_sched.sv
// tb/tb_overlay_wr_sched.sv - randomized and directed self-checking bench for overlay_wr_sched
module tb_overlay_wr_sched;
    import overlay_pkg::*;

    localparam int NREQ = 4;
    localparam int AW   = 11;
    localparam int DW   = 8;
    localparam int LW   = 5;
    localparam int IW   = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               vblank = 1'b0;
    logic               vblank_only = 1'b0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*LW-1:0] req_len = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_done;
    logic               wr_ena;
    logic [AW-1:0]      wr_addr;
    logic [DW-1:0]      wr_data;
    logic               busy;
    logic [IW-1:0]      grant_idx;

    overlay_wr_sched #(.NREQ(NREQ), .AW(AW), .DW(DW), .LW(LW)) dut (
        .i_clk       (clk),
        .reset       (reset),
        .vblank      (vblank),
        .vblank_only (vblank_only),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .req_done    (req_done),
        .wr_ena      (wr_ena),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .grant_idx   (grant_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Requester agents
    bit        active[NREQ];
    bit        hold[NREQ];
    bit        rearm[NREQ];
    int        a_addr[NREQ];
    int        a_len[NREQ];
    int        hs[NREQ];
    bit        fired[NREQ];
    logic [7:0] seed[NREQ];
    bit        rnd_mode = 0;

    task automatic drive_inputs();
        for (int r = 0; r < NREQ; r++) begin
            logic [7:0] d;
            d = seed[r] + 8'(hs[r]);
            req_valid[r]            = active[r] && !hold[r];
            req_addr[r*AW +: AW]    = AW'(a_addr[r]);
            req_len[r*LW +: LW]     = LW'(a_len[r]);
            req_data[r*DW +: DW]    = d;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #2;
        for (int r = 0; r < NREQ; r++) begin
            if (fired[r]) hs[r]++;
            if (req_done[r] && !rearm[r]) active[r] = 0;
        end
        if (rnd_mode) begin
            for (int r = 0; r < NREQ; r++) begin
                if (!active[r] && $urandom_range(0, 3) == 0) begin
                    active[r] = 1;
                    a_addr[r] = $urandom_range(0, 2047);
                    a_len[r]  = ($urandom_range(0, 9) == 0) ? 31 : $urandom_range(0, 5);
                end
                hold[r] = ($urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 5) == 0) vblank = ~vblank;
            if ($urandom_range(0, 49) == 0) vblank_only = ~vblank_only;
            reset = ($urandom_range(0, 299) == 0);
        end
        drive_inputs();
    endtask

    // Behavioural reference model, advanced on each rising edge
    int         m_g = -1;
    int         m_base = 0, m_len = 0, m_beat = 0, m_rr = 0, m_wcount = 0;
    logic       e_wr = 0, e_busy = 0;
    logic [AW-1:0] e_addr = 0;
    logic [DW-1:0] e_data = 0;
    logic [NREQ-1:0] e_done = 0;
    int         e_gidx = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_g = -1; m_rr = 0; m_beat = 0;
            e_wr = 0; e_addr = 0; e_data = 0; e_done = 0; e_busy = 0; e_gidx = 0;
        end else begin
            bit gate, got;
            gate = !vblank_only || vblank;
            e_wr = 0;
            e_done = 0;
            got = 0;
            if (m_g < 0) begin
                if (gate) begin
                    for (int k = 0; k < NREQ; k++) begin
                        if (!got && req_valid[(m_rr + k) % NREQ]) begin
                            got    = 1;
                            m_g    = (m_rr + k) % NREQ;
                            m_base = int'(req_addr[m_g*AW +: AW]);
                            m_len  = int'(req_len[m_g*LW +: LW]);
                            m_beat = 0;
                            e_busy = 1;
                            e_gidx = m_g;
                        end
                    end
                end
            end else if (gate && req_valid[m_g]) begin
                e_wr   = 1;
                e_addr = AW'((m_base + m_beat) % (1 << AW));
                e_data = req_data[m_g*DW +: DW];
                m_beat++;
                m_wcount++;
                if (m_beat == m_len + 1) begin
                    e_done[m_g] = 1'b1;
                    e_busy = 0;
                    m_rr = (m_g + 1) % NREQ;
                    m_g = -1;
                end
            end
        end
    end

    // Per-cycle compare and observation logs
    int cyc = 0;
    int busycnt = 0;
    bit prev_busy = 0;
    int wlog_a[$], wlog_d[$], wcyc[$], dlog_i[$], dcyc[$], glog[$];

    always @(negedge clk) begin
        logic [NREQ-1:0] e_ready;
        cyc++;
        for (int r = 0; r < NREQ; r++) fired[r] = req_valid[r] && req_ready[r];
        e_ready = '0;
        if (m_g >= 0 && (!vblank_only || vblank)) e_ready[m_g] = 1'b1;
        if (chk_en) begin
            chk("wr_ena", 32'(wr_ena), 32'(e_wr));
            chk("wr_addr", 32'(wr_addr), 32'(e_addr));
            chk("wr_data", 32'(wr_data), 32'(e_data));
            chk("req_done", 32'(req_done), 32'(e_done));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("grant_idx", 32'(grant_idx), 32'(e_gidx));
            chk("req_ready", 32'(req_ready), 32'(e_ready));
        end
        if (wr_ena === 1'b1) begin
            wlog_a.push_back(int'(wr_addr));
            wlog_d.push_back(int'(wr_data));
            wcyc.push_back(cyc);
        end
        for (int r = 0; r < NREQ; r++) begin
            if (req_done[r] === 1'b1) begin
                dlog_i.push_back(r);
                dcyc.push_back(cyc);
            end
        end
        if (busy === 1'b1 || req_done !== '0) busycnt++;
        if (busy === 1'b1 && !prev_busy) glog.push_back(int'(grant_idx));
        prev_busy = (busy === 1'b1);
    end

    task automatic clear_logs();
        wlog_a.delete(); wlog_d.delete(); wcyc.delete();
        dlog_i.delete(); dcyc.delete(); glog.delete();
        busycnt = 0;
        m_wcount = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        for (int r = 0; r < NREQ; r++) begin
            active[r] = 0; hold[r] = 0; rearm[r] = 0; hs[r] = 0;
            a_addr[r] = 0; a_len[r] = 0;
        end
        drive_inputs();
        cycle();
        cycle();
        reset = 0;
        drive_inputs();
        clear_logs();
    endtask

    task automatic wait_busy(input string nm, input int bound);
        int n = 0;
        while (busy !== 1'b1 && n < bound) begin cycle(); n++; end
        if (busy !== 1'b1) chk(nm, 0, 1);
    endtask

    task automatic wait_done(input string nm, input int bound);
        int n = 0;
        while (dlog_i.size() == 0 && n < bound) begin cycle(); n++; end
        if (dlog_i.size() == 0) chk(nm, 0, 1);
    endtask

    initial begin
        seed[0] = CHR_GEAR; seed[1] = CHR_BAR; seed[2] = CHR_FILL; seed[3] = CHR_TEXT;
        do_reset();
        chk_en = 1;

        // Reset state
        chk("rst_wr_ena", 32'(wr_ena), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_req_done", 32'(req_done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant_idx", 32'(grant_idx), 0);
        chk("rst_req_ready", 32'(req_ready), 0);

        // Single 16-beat burst, no gate
        vblank_only = 0;
        active[1] = 1; a_addr[1] = 136; a_len[1] = 15;
        drive_inputs();
        wait_done("t1_timeout", 40);
        cycle(); cycle();
        chk("t1_nwrites", wlog_a.size(), 16);
        chk("t1_model_nwrites", m_wcount, 16);
        if (wlog_a.size() == 16) begin
            for (int k = 0; k < 16; k++) begin
                chk("t1_addr", wlog_a[k], 136 + k);
                chk("t1_data", wlog_d[k], (8'h96 + k) & 8'hFF);
            end
            chk("t1_back_to_back", wcyc[15] - wcyc[0], 15);
            if (dcyc.size() > 0) chk("t1_done_on_last", dcyc[0], wcyc[15]);
        end
        chk("t1_ndone", dlog_i.size(), 1);
        if (dlog_i.size() > 0) chk("t1_done_idx", dlog_i[0], 1);
        chk("t1_busy_span", busycnt, 17);

        // Round-robin of single-beat bursts
        do_reset();
        foreach (active[r]) begin
            if (r != 1) begin active[r] = 1; rearm[r] = 1; a_len[r] = 0; a_addr[r] = 40 * r; end
        end
        drive_inputs();
        repeat (16) cycle();
        chk("t2_ngrants", 32'(glog.size() >= 6), 1);
        if (glog.size() >= 6 && wcyc.size() >= 6) begin
            chk("t2_g0", glog[0], 0); chk("t2_g1", glog[1], 2); chk("t2_g2", glog[2], 3);
            chk("t2_g3", glog[3], 0); chk("t2_g4", glog[4], 2); chk("t2_g5", glog[5], 3);
            for (int k = 0; k < 5; k++) chk("t2_spacing", wcyc[k+1] - wcyc[k], 2);
        end

        // Gate and stall
        do_reset();
        vblank_only = 1; vblank = 0;
        active[0] = 1; a_addr[0] = 500; a_len[0] = 3;
        drive_inputs();
        repeat (5) cycle();
        chk("t3_no_grant_closed", 32'(busy), 0);
        chk("t3_no_write_closed", wlog_a.size(), 0);
        vblank = 1; drive_inputs();
        wait_busy("t3_grant_timeout", 5);
        cycle(); cycle();
        vblank = 0; drive_inputs();
        repeat (10) cycle();
        vblank = 1; drive_inputs();
        wait_done("t3_timeout", 10);
        cycle();
        chk("t3_nwrites", wlog_a.size(), 4);
        if (wlog_a.size() == 4) begin
            for (int k = 0; k < 4; k++) chk("t3_addr", wlog_a[k], 500 + k);
            chk("t3_pair1", wcyc[1] - wcyc[0], 1);
            chk("t3_gap", wcyc[2] - wcyc[1], 11);
            chk("t3_pair2", wcyc[3] - wcyc[2], 1);
        end
        vblank_only = 0;

        // Valid drop mid-burst with address wrap
        do_reset();
        active[3] = 1; a_addr[3] = 2046; a_len[3] = 3;
        drive_inputs();
        wait_busy("t4_grant_timeout", 5);
        cycle(); cycle();
        hold[3] = 1; drive_inputs();
        cycle(); cycle();
        hold[3] = 0; drive_inputs();
        wait_done("t4_timeout", 10);
        cycle(); cycle();
        chk("t4_nwrites", wlog_a.size(), 4);
        if (wlog_a.size() == 4) begin
            chk("t4_a0", wlog_a[0], 2046); chk("t4_a1", wlog_a[1], 2047);
            chk("t4_a2", wlog_a[2], 0);    chk("t4_a3", wlog_a[3], 1);
            chk("t4_gap", wcyc[2] - wcyc[1], 3);
        end
        chk("t4_ndone", dlog_i.size(), 1);
        if (dlog_i.size() > 0) chk("t4_done_idx", dlog_i[0], 3);

        // Reset mid-burst, pointer returns to requester 0
        do_reset();
        active[2] = 1; a_len[2] = 0; a_addr[2] = 7;
        drive_inputs();
        wait_done("t5_pre_timeout", 10);
        cycle();
        clear_logs();
        active[1] = 1; a_addr[1] = 300; a_len[1] = 15;
        drive_inputs();
        wait_busy("t5_grant_timeout", 5);
        repeat (4) cycle();
        reset = 1; drive_inputs();
        cycle();
        chk("t5_wr_ena", 32'(wr_ena), 0);
        chk("t5_wr_addr", 32'(wr_addr), 0);
        chk("t5_wr_data", 32'(wr_data), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_grant_idx", 32'(grant_idx), 0);
        chk("t5_req_ready", 32'(req_ready), 0);
        chk("t5_req_done", 32'(req_done), 0);
        chk("t5_partial_writes", wlog_a.size(), 4);
        reset = 0;
        active[0] = 1; a_len[0] = 0;
        active[3] = 1; a_len[3] = 0;
        drive_inputs();
        wait_busy("t5_regrant_timeout", 5);
        chk("t5_regrant_idx", 32'(grant_idx), 0);
        chk("t5_no_done", dlog_i.size(), 0);

        // Randomized traffic against the model
        do_reset();
        rnd_mode = 1;
        repeat (3000) cycle();
        rnd_mode = 0;
        reset = 0;
        drive_inputs();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
